enemy_sched: RTL and testbench

ENEMY_SCHED -- requirements
Module: enemy_sched

---
 rtl/enemy_sched.sv | 173 +++++++++++++++++
 tb/tb_enemy_sched.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_sched.sv
// Four-slot enemy scheduler: spawn pacing, hit/explode/cool-down lifecycle, kill counter.
// Build option: define ENEMY_SCHED_LFSR_EN to draw spawn positions from an LFSR instead of a stride counter.
module enemy_sched #(
    parameter int SPAWN_TICKS   = 8,
    parameter int HIT_TICKS     = 4,
    parameter int RESPAWN_TICKS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        enable,
    input  logic [3:0]  hit,
    output logic [19:0] pos,
    output logic [3:0]  active,
    output logic [3:0]  exploding,
    output logic [3:0]  damage,
    output logic [7:0]  kill_cnt
);
    localparam logic [4:0] SPAWN_LAST   = 5'(SPAWN_TICKS - 1);
    localparam logic [4:0] HIT_LAST     = 5'(HIT_TICKS - 1);
    localparam logic [4:0] RESPAWN_LAST = 5'(RESPAWN_TICKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HIT, S_COOL} slot_state_t;

    logic       eff_tick;
    logic [4:0] spawn_cnt_reg, spawn_cnt_next;
    logic [4:0] cand;
    logic [3:0] idle_vec, collide_vec, accept, spawn_sel;
    logic       spawn_ok;
    logic [2:0] accept_cnt;
    logic [8:0] kill_sum;
    logic [7:0] kill_cnt_reg;
    logic [3:0] damage_reg;

    assign eff_tick = tick & enable;

    // A spawn needs the pacing counter expired, a free slot and a candidate position nobody is drawn at.
    assign spawn_ok  = eff_tick && (spawn_cnt_reg == SPAWN_LAST) && (|idle_vec) && !(|collide_vec);
    assign spawn_sel = spawn_ok ? (idle_vec & (~idle_vec + 4'd1)) : 4'd0;

    always_comb begin
        spawn_cnt_next = spawn_cnt_reg;
        if (spawn_ok) begin
            spawn_cnt_next = '0;
        end else if (eff_tick && (spawn_cnt_reg != SPAWN_LAST)) begin
            spawn_cnt_next = spawn_cnt_reg + 5'd1;
        end
    end

`ifdef ENEMY_SCHED_LFSR_EN
    logic [4:0] lfsr_reg;

    assign cand = (lfsr_reg > 5'd21) ? (lfsr_reg - 5'd11) : lfsr_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_reg <= 5'b00001;
        end else if (eff_tick) begin
            lfsr_reg <= {lfsr_reg[3:0], lfsr_reg[4] ^ lfsr_reg[2]};
        end
    end
`else
    logic [4:0] cand_reg;

    assign cand = cand_reg;

    // Stride of 7 modulo 22 visits every lane before repeating.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cand_reg <= '0;
        end else if (spawn_ok) begin
            cand_reg <= (cand_reg >= 5'd15) ? (cand_reg - 5'd15) : (cand_reg + 5'd7);
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            slot_state_t state_reg, state_next;
            logic [4:0]  timer_reg, timer_next;
            logic [4:0]  pos_reg;
            logic        active_reg, exploding_reg;

            assign idle_vec[gi]    = (state_reg == S_IDLE);
            assign accept[gi]      = enable && hit[gi] && (state_reg == S_ACTIVE);
            assign collide_vec[gi] = ((state_reg == S_ACTIVE) || (state_reg == S_HIT)) && (pos_reg == cand);

            always_comb begin
                state_next = state_reg;
                timer_next = timer_reg;
                case (state_reg)
                    S_IDLE: begin
                        if (spawn_sel[gi]) begin
                            state_next = S_ACTIVE;
                            timer_next = '0;
                        end
                    end
                    S_ACTIVE: begin
                        if (accept[gi]) begin
                            state_next = S_HIT;
                            timer_next = '0;
                        end
                    end
                    S_HIT: begin
                        if (eff_tick) begin
                            if (timer_reg == HIT_LAST) begin
                                state_next = S_COOL;
                                timer_next = '0;
                            end else begin
                                timer_next = timer_reg + 5'd1;
                            end
                        end
                    end
                    S_COOL: begin
                        if (eff_tick) begin
                            if (timer_reg == RESPAWN_LAST) begin
                                state_next = S_IDLE;
                                timer_next = '0;
                            end else begin
                                timer_next = timer_reg + 5'd1;
                            end
                        end
                    end
                    default: begin
                        state_next = S_IDLE;
                        timer_next = '0;
                    end
                endcase
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    state_reg     <= S_IDLE;
                    timer_reg     <= '0;
                    pos_reg       <= '0;
                    active_reg    <= 1'b0;
                    exploding_reg <= 1'b0;
                end else begin
                    state_reg     <= state_next;
                    timer_reg     <= timer_next;
                    if (spawn_sel[gi]) begin
                        pos_reg <= cand;
                    end
                    active_reg    <= (state_next == S_ACTIVE) || (state_next == S_HIT);
                    exploding_reg <= (state_next == S_HIT);
                end
            end

            assign pos[5*gi +: 5] = pos_reg;
            assign active[gi]     = active_reg;
            assign exploding[gi]  = exploding_reg;
        end
    endgenerate

    assign accept_cnt = 3'(accept[0]) + 3'(accept[1]) + 3'(accept[2]) + 3'(accept[3]);
    assign kill_sum   = {1'b0, kill_cnt_reg} + {6'd0, accept_cnt};

    always_ff @(posedge clk) begin
        if (!rst) begin
            spawn_cnt_reg <= '0;
            damage_reg    <= '0;
            kill_cnt_reg  <= '0;
        end else begin
            spawn_cnt_reg <= spawn_cnt_next;
            damage_reg    <= accept;
            kill_cnt_reg  <= kill_sum[8] ? 8'hFF : kill_sum[7:0];
        end
    end

    assign damage   = damage_reg;
    assign kill_cnt = kill_cnt_reg;
endmodule

// File: tb/tb_enemy_sched.sv
// Bench for enemy_sched: a default instance plus a fast (all timers = 1) instance for collision and saturation.
module tb_enemy_sched;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, tick, enable, tick_b, enable_b;
    logic [3:0]  hit, hit_b;
    logic [19:0] pos, pos_b;
    logic [3:0]  active, exploding, damage, active_b, exploding_b, damage_b;
    logic [7:0]  kill_cnt, kill_cnt_b;

    enemy_sched u_dut (
        .clk(clk), .rst(rst), .tick(tick), .enable(enable), .hit(hit),
        .pos(pos), .active(active), .exploding(exploding), .damage(damage), .kill_cnt(kill_cnt)
    );

    enemy_sched #(.SPAWN_TICKS(1), .HIT_TICKS(1), .RESPAWN_TICKS(1)) u_fast (
        .clk(clk), .rst(rst), .tick(tick_b), .enable(enable_b), .hit(hit_b),
        .pos(pos_b), .active(active_b), .exploding(exploding_b), .damage(damage_b), .kill_cnt(kill_cnt_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: per-slot lifecycle with countdowns, spawn pacing as "ticks until next attempt".
    function automatic int p_spawn(input int k); return (k == 0) ? 8 : 1; endfunction
    function automatic int p_hit(input int k);   return (k == 0) ? 4 : 1; endfunction
    function automatic int p_resp(input int k);  return (k == 0) ? 16 : 1; endfunction

    int         m_state [2][4];   // 0 idle, 1 active, 2 hit, 3 cool
    int         m_left  [2][4];
    int         m_pos   [2][4];
    int         m_wait  [2];
    int         m_spawns[2];
    int         m_kills [2];
    logic [3:0] m_dmg   [2];
    bit         m_valid [2];

    task automatic model_step(input int k, input logic r, input logic t, input logic e, input logic [3:0] h);
        int old_state[4];
        bit eff, blocked;
        int cand, pick;
        if (!r) begin
            for (int s = 0; s < 4; s++) begin
                m_state[k][s] = 0; m_left[k][s] = 0; m_pos[k][s] = 0;
            end
            m_wait[k] = p_spawn(k); m_spawns[k] = 0; m_kills[k] = 0; m_dmg[k] = '0; m_valid[k] = 1'b1;
            return;
        end
        eff = t && e;
        m_dmg[k] = '0;
        for (int s = 0; s < 4; s++) old_state[s] = m_state[k][s];
        for (int s = 0; s < 4; s++) begin
            case (old_state[s])
                1: if (e && h[s]) begin
                    m_state[k][s] = 2; m_left[k][s] = p_hit(k); m_kills[k]++; m_dmg[k][s] = 1'b1;
                end
                2: if (eff) begin
                    m_left[k][s]--;
                    if (m_left[k][s] == 0) begin m_state[k][s] = 3; m_left[k][s] = p_resp(k); end
                end
                3: if (eff) begin
                    m_left[k][s]--;
                    if (m_left[k][s] == 0) m_state[k][s] = 0;
                end
                default: ;
            endcase
        end
        if (eff) begin
            if (m_wait[k] > 1) begin
                m_wait[k]--;
            end else begin
                cand = (7 * m_spawns[k]) % 22;
                pick = -1; blocked = 1'b0;
                for (int s = 3; s >= 0; s--) if (old_state[s] == 0) pick = s;
                for (int s = 0; s < 4; s++)
                    if ((old_state[s] == 1 || old_state[s] == 2) && m_pos[k][s] == cand) blocked = 1'b1;
                if (pick >= 0 && !blocked) begin
                    m_state[k][pick] = 1; m_pos[k][pick] = cand; m_spawns[k]++; m_wait[k] = p_spawn(k);
                end
            end
        end
    endtask

    function automatic logic [19:0] e_pos(input int k);
        logic [19:0] r;
        r = '0;
        for (int s = 0; s < 4; s++) r[5*s +: 5] = 5'(m_pos[k][s]);
        return r;
    endfunction

    function automatic logic [3:0] e_state(input int k, input int lo, input int hi);
        logic [3:0] r;
        r = '0;
        for (int s = 0; s < 4; s++) r[s] = (m_state[k][s] >= lo) && (m_state[k][s] <= hi);
        return r;
    endfunction

    task automatic compare(input int k, input string pfx, input logic [19:0] p, input logic [3:0] a,
                           input logic [3:0] x, input logic [3:0] d, input logic [7:0] kc);
        chk({pfx, ".pos"}, 32'(p), 32'(e_pos(k)));
        chk({pfx, ".active"}, 32'(a), 32'(e_state(k, 1, 2)));
        chk({pfx, ".exploding"}, 32'(x), 32'(e_state(k, 2, 2)));
        chk({pfx, ".damage"}, 32'(d), 32'(m_dmg[k]));
        chk({pfx, ".kill_cnt"}, 32'(kc), (m_kills[k] > 255) ? 32'd255 : 32'(m_kills[k]));
    endtask

    // Outputs settled after the rising edge are checked here; then the model consumes the inputs for the next edge.
    always @(negedge clk) begin
        if (m_valid[0]) compare(0, "dut", pos, active, exploding, damage, kill_cnt);
        if (m_valid[1]) compare(1, "fast", pos_b, active_b, exploding_b, damage_b, kill_cnt_b);
        model_step(0, rst, tick, enable, hit);
        model_step(1, rst, tick_b, enable_b, hit_b);
    end

    task automatic step(input logic r, input logic t, input logic e, input logic [3:0] h);
        rst = r; tick = t; enable = e; hit = h;
        tick_b = 1'b0; enable_b = 1'b1; hit_b = 4'd0;
        @(posedge clk); #1;
    endtask

    task automatic stepb(input logic t, input logic [3:0] h);
        rst = 1'b1; tick = 1'b0; enable = 1'b1; hit = 4'd0;
        tick_b = t; enable_b = 1'b1; hit_b = h;
        @(posedge clk); #1;
    endtask

    initial begin
        step(1'b0, 1'b0, 1'b1, 4'd0);
        step(1'b0, 1'b0, 1'b1, 4'd0);
        chk("rst.pos", 32'(pos), 32'd0);
        chk("rst.active", 32'(active), 32'd0);
        chk("rst.kill", 32'(kill_cnt), 32'd0);

        // First spawn lands on the 8th effective tick, then the stride fills 0,7,14,21.
        repeat (7) step(1'b1, 1'b1, 1'b1, 4'd0);
        chk("pre_spawn.active", 32'(active), 32'd0);
        step(1'b1, 1'b1, 1'b1, 4'd0);
        chk("spawn0.active", 32'(active), 32'b0001);
        chk("spawn0.pos", 32'(pos[4:0]), 32'd0);
        repeat (24) step(1'b1, 1'b1, 1'b1, 4'd0);
        chk("fill.active", 32'(active), 32'b1111);
        chk("fill.pos", 32'(pos), 32'({5'd21, 5'd14, 5'd7, 5'd0}));

        // Held hit on slot 1 counts once.
        step(1'b1, 1'b0, 1'b1, 4'b0010);
        chk("hit1.damage", 32'(damage), 32'b0010);
        chk("hit1.kill", 32'(kill_cnt), 32'd1);
        chk("hit1.exploding", 32'(exploding), 32'b0010);
        step(1'b1, 1'b0, 1'b1, 4'b0010);
        chk("hit1.damage_once", 32'(damage), 32'd0);
        step(1'b1, 1'b0, 1'b1, 4'b0010);
        chk("hit1.kill_once", 32'(kill_cnt), 32'd1);
        repeat (3) step(1'b1, 1'b1, 1'b1, 4'd0);
        chk("hit1.still_exploding", 32'(exploding), 32'b0010);
        step(1'b1, 1'b1, 1'b1, 4'd0);
        chk("hit1.cool", 32'(active), 32'b1101);
        repeat (16) step(1'b1, 1'b1, 1'b1, 4'd0);
        chk("hit1.idle_not_eligible", 32'(active), 32'b1101);
        step(1'b1, 1'b1, 1'b1, 4'd0);
        chk("respawn1.active", 32'(active), 32'b1111);
        chk("respawn1.pos", 32'(pos[9:5]), 32'd6);

        step(1'b1, 1'b0, 1'b1, 4'b1111);
        chk("hitall.damage", 32'(damage), 32'b1111);
        chk("hitall.kill", 32'(kill_cnt), 32'd5);
        step(1'b1, 1'b0, 1'b1, 4'd0);
        chk("hitall.damage_clear", 32'(damage), 32'd0);

        repeat (5) step(1'b1, 1'b1, 1'b0, 4'b1111);
        chk("disabled.exploding", 32'(exploding), 32'b1111);
        chk("disabled.kill", 32'(kill_cnt), 32'd5);

        // Reset mid-HIT with a coincident tick and hit.
        repeat (2) step(1'b1, 1'b1, 1'b1, 4'd0);
        step(1'b0, 1'b1, 1'b1, 4'b1111);
        chk("midrst.pos", 32'(pos), 32'd0);
        chk("midrst.active", 32'(active), 32'd0);
        chk("midrst.exploding", 32'(exploding), 32'd0);
        chk("midrst.damage", 32'(damage), 32'd0);
        chk("midrst.kill", 32'(kill_cnt), 32'd0);
        repeat (7) step(1'b1, 1'b1, 1'b1, 4'd0);
        chk("midrst.pre_spawn", 32'(active), 32'd0);
        step(1'b1, 1'b1, 1'b1, 4'd0);
        chk("midrst.spawn", 32'(active), 32'b0001);
        chk("midrst.spawn_pos", 32'(pos), 32'd0);

        // Spawn into slot 1 and hit+tick on slot 0 in the same cycle.
        repeat (7) step(1'b1, 1'b1, 1'b1, 4'd0);
        step(1'b1, 1'b1, 1'b1, 4'b0001);
        chk("both.active", 32'(active), 32'b0011);
        chk("both.exploding", 32'(exploding), 32'b0001);
        chk("both.damage", 32'(damage), 32'b0001);
        chk("both.pos1", 32'(pos[9:5]), 32'd7);
        repeat (3) step(1'b1, 1'b1, 1'b1, 4'd0);
        chk("both.timer_from_zero", 32'(exploding), 32'b0001);
        step(1'b1, 1'b1, 1'b1, 4'd0);
        chk("both.hit_done", 32'(exploding), 32'd0);

        // Fast instance: keep slot 0 alive at pos 0 until the stride wraps back onto it.
        repeat (80) stepb(1'b1, active_b & 4'b1110);
        chk("collide.active", 32'(active_b), 32'b0001);
        chk("collide.pos0", 32'(pos_b[4:0]), 32'd0);
        stepb(1'b1, 4'b0001);
        chk("collide.hit_blocks", 32'(active_b), 32'b0001);
        chk("collide.exploding", 32'(exploding_b), 32'b0001);
        stepb(1'b1, 4'd0);
        chk("collide.cool", 32'(active_b), 32'd0);
        stepb(1'b1, 4'd0);
        chk("collide.freed", 32'(active_b), 32'b0010);
        chk("collide.freed_pos", 32'(pos_b[9:5]), 32'd0);

        repeat (600) stepb(1'b1, 4'b1111);
        chk("saturate.kill", 32'(kill_cnt_b), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
